// File: rtl/reg_wb_arbiter_if.sv
// Result-source handshake and register-file write-port bundle for reg_wb_arbiter.
// master = producers/consumer side (execution units, regfile); slave = the arbiter.
interface reg_wb_arbiter_if #(
    parameter int NSRC = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NSRC-1:0]    src_valid;
    logic [NSRC-1:0]    src_ready;
    logic [NSRC*AW-1:0] src_addr;
    logic [NSRC*DW-1:0] src_data;
    logic               wb_stall;
    logic               wb_we;
    logic [AW-1:0]      wb_addr;
    logic [DW-1:0]      wb_data;

    modport master (
        output src_valid, src_addr, src_data, wb_stall,
        input  src_ready, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  src_valid, src_addr, src_data, wb_stall,
        output src_ready, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter: NSRC result sources -> in-order FIFO -> one regfile write/cycle,
// with a per-register busy scoreboard. Define WB_BYPASS_EN for a 1-cycle path when the FIFO is empty.
module reg_wb_arbiter #(
    parameter int NSRC  = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    reg_wb_arbiter_if.slave            bus,
    input  logic                       claim_valid,
    input  logic [AW-1:0]              claim_addr,
    output logic [(2**AW)-1:0]         busy_vec,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       dbl_claim
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int FW = $clog2(DEPTH);
    localparam int CW = FW + 1;
    localparam int NREG = 2 ** AW;

    logic [PW-1:0] rr_ptr;
    logic [NSRC-1:0] grant;
    logic [PW-1:0] grant_idx;
    logic          grant_found;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic pop;
    logic can_push;
    logic accept;
    logic bypass;
    logic push;

    logic [NREG-1:0] busy_next;
    logic            claim_ok;

    assign pop      = (count != '0) && !bus.wb_stall && !flush;
    assign can_push = !flush && ((count < CW'(DEPTH)) || pop);

    // Search begins just after the last granted source so every source gets a turn.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NSRC; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NSRC;
            if (!grant_found && bus.src_valid[idx] && can_push) begin
                grant_found    = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PW'(idx);
            end
        end
    end

    assign bus.src_ready = grant;
    assign accept        = grant_found;
    assign sel_addr      = bus.src_addr[grant_idx*AW +: AW];
    assign sel_data      = bus.src_data[grant_idx*DW +: DW];

`ifdef WB_BYPASS_EN
    assign bypass = accept && (count == '0) && !bus.wb_stall && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    // NOTE: storage arrays carry no reset; validity is tracked entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= sel_addr;
            mem_data[wr_ptr] <= sel_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= PW'(NSRC - 1);
        end else begin
            if (accept) rr_ptr <= grant_idx;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_we   <= 1'b0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
        end else if (pop) begin
            bus.wb_we   <= 1'b1;
            bus.wb_addr <= mem_addr[rd_ptr];
            bus.wb_data <= mem_data[rd_ptr];
        end else if (bypass) begin
            bus.wb_we   <= 1'b1;
            bus.wb_addr <= sel_addr;
            bus.wb_data <= sel_data;
        end else begin
            bus.wb_we   <= 1'b0;
        end
    end

    // Retire clears first, then a claim sets, so a same-edge claim on the retiring register wins.
    assign claim_ok = claim_valid && !flush;

    // NOTE: combinational next-state gets a full default first so no latch is inferred.
    always_comb begin
        busy_next = busy_vec;
        if (bus.wb_we) busy_next[bus.wb_addr] = 1'b0;
        if (claim_ok)  busy_next[claim_addr]  = 1'b1;
        if (flush)     busy_next              = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec  <= '0;
            dbl_claim <= 1'b0;
        end else begin
            busy_vec <= busy_next;
            if (claim_ok && busy_vec[claim_addr]) dbl_claim <= 1'b1;
        end
    end

    assign fifo_count = count;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed, table-driven bench for reg_wb_arbiter: round-robin order, FIFO full/stall,
// scoreboard set/clear/double-claim, flush and asynchronous reset.
module tb_reg_wb_arbiter;
    localparam int NSRC = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            claim_valid;
    logic [AW-1:0]   claim_addr;
    logic [31:0]     busy_vec;
    logic [2:0]      fifo_count;
    logic            dbl_claim;

    int n_checks = 0;
    int n_err    = 0;

    reg_wb_arbiter_if #(.NSRC(NSRC), .AW(AW), .DW(DW)) bus ();

    reg_wb_arbiter #(.NSRC(NSRC), .DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .busy_vec    (busy_vec),
        .fifo_count  (fifo_count),
        .dbl_claim   (dbl_claim)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic       we;
        logic [4:0] addr;
        logic [2:0] count;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.src_addr[i*AW +: AW] = a;
        bus.src_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        flush          = 1'b0;
        claim_valid    = 1'b0;
        claim_addr     = '0;
        bus.src_valid  = '0;
        bus.src_addr   = '0;
        bus.src_data   = '0;
        bus.wb_stall   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Round-robin table: sources hold addr 8+i, data D000_0000+i.
        vecs[0]  = '{4'hF,    4'b0001, 1'b0, 5'd0,  3'd0};
        vecs[1]  = '{4'hF,    4'b0010, 1'b0, 5'd0,  3'd1};
        vecs[2]  = '{4'hF,    4'b0100, 1'b1, 5'd8,  3'd1};
        vecs[3]  = '{4'hF,    4'b1000, 1'b1, 5'd9,  3'd1};
        vecs[4]  = '{4'h0,    4'b0000, 1'b1, 5'd10, 3'd1};
        vecs[5]  = '{4'h0,    4'b0000, 1'b1, 5'd11, 3'd0};
        vecs[6]  = '{4'b0100, 4'b0100, 1'b0, 5'd11, 3'd0};
        vecs[7]  = '{4'b1010, 4'b1000, 1'b0, 5'd11, 3'd1};
        vecs[8]  = '{4'b0010, 4'b0010, 1'b1, 5'd10, 3'd1};
        vecs[9]  = '{4'h0,    4'b0000, 1'b1, 5'd11, 3'd1};
        vecs[10] = '{4'h0,    4'b0000, 1'b1, 5'd9,  3'd0};
        vecs[11] = '{4'h0,    4'b0000, 1'b0, 5'd9,  3'd0};

        // ---- Test 1: single write latency and reset state ----
        do_reset();
        @(negedge clk);
        check("rst wb_we", 64'(bus.wb_we), 64'd0);
        check("rst wb_addr", 64'(bus.wb_addr), 64'd0);
        check("rst wb_data", 64'(bus.wb_data), 64'd0);
        check("rst busy_vec", 64'(busy_vec), 64'd0);
        check("rst fifo_count", 64'(fifo_count), 64'd0);
        check("rst dbl_claim", 64'(dbl_claim), 64'd0);
        check("rst src_ready", 64'(bus.src_ready), 64'd0);
        tick();
        set_src(0, 5'd3, 32'hDEADBEEF);
        bus.src_valid = 4'b0001;
        @(negedge clk);
        check("t1 ready", 64'(bus.src_ready), 64'b0001);
        tick();
        bus.src_valid = '0;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("t1 bypass we", 64'(bus.wb_we), 64'd1);
        check("t1 bypass addr", 64'(bus.wb_addr), 64'd3);
        check("t1 bypass data", 64'(bus.wb_data), 64'hDEADBEEF);
        check("t1 bypass count", 64'(fifo_count), 64'd0);
        tick();
        @(negedge clk);
        check("t1 we drop", 64'(bus.wb_we), 64'd0);
`else
        check("t1 queued we", 64'(bus.wb_we), 64'd0);
        check("t1 queued count", 64'(fifo_count), 64'd1);
        tick();
        @(negedge clk);
        check("t1 we", 64'(bus.wb_we), 64'd1);
        check("t1 addr", 64'(bus.wb_addr), 64'd3);
        check("t1 data", 64'(bus.wb_data), 64'hDEADBEEF);
        check("t1 count", 64'(fifo_count), 64'd0);
        tick();
        @(negedge clk);
        check("t1 we drop", 64'(bus.wb_we), 64'd0);
`endif

`ifndef WB_BYPASS_EN
        // ---- Test 2: round-robin table ----
        do_reset();
        for (int i = 0; i < NSRC; i++) set_src(i, AW'(8 + i), 32'hD000_0000 + i);
        for (int i = 0; i < 12; i++) begin
            bus.src_valid = vecs[i].valid;
            @(negedge clk);
            check($sformatf("rr[%0d] ready", i), 64'(bus.src_ready), 64'(vecs[i].ready));
            check($sformatf("rr[%0d] we", i), 64'(bus.wb_we), 64'(vecs[i].we));
            check($sformatf("rr[%0d] addr", i), 64'(bus.wb_addr), 64'(vecs[i].addr));
            check($sformatf("rr[%0d] count", i), 64'(fifo_count), 64'(vecs[i].count));
            if (vecs[i].we)
                check($sformatf("rr[%0d] data", i), 64'(bus.wb_data),
                      64'(32'hD000_0000 + 32'(vecs[i].addr) - 32'd8));
            tick();
        end

        // ---- Test 3: full FIFO under stall, then drain with simultaneous push ----
        do_reset();
        bus.wb_stall  = 1'b1;
        set_src(1, 5'd16, 32'h3000 + 16);
        bus.src_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("fill[%0d] ready", k), 64'(bus.src_ready), 64'b0010);
            check($sformatf("fill[%0d] count", k), 64'(fifo_count), 64'(k));
            tick();
            set_src(1, AW'(17 + k), 32'h3000 + 32'(17 + k));
        end
        @(negedge clk);
        check("full count", 64'(fifo_count), 64'd4);
        check("full ready", 64'(bus.src_ready), 64'd0);
        tick();
        bus.wb_stall = 1'b0;
        @(negedge clk);
        check("release ready", 64'(bus.src_ready), 64'b0010);
        check("release count", 64'(fifo_count), 64'd4);
        tick();
        bus.src_valid = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("drain[%0d] we", k), 64'(bus.wb_we), 64'd1);
            check($sformatf("drain[%0d] addr", k), 64'(bus.wb_addr), 64'(16 + k));
            check($sformatf("drain[%0d] data", k), 64'(bus.wb_data), 64'(32'h3000 + 32'(16 + k)));
            check($sformatf("drain[%0d] count", k), 64'(fifo_count), 64'(4 - k));
            tick();
        end
`endif

        // ---- Test 4: scoreboard ----
        do_reset();
        claim_valid = 1'b1;
        claim_addr  = 5'd7;
        tick();
        claim_valid = 1'b0;
        @(negedge clk);
        check("claim busy", 64'(busy_vec), 64'h80);
        check("claim dbl", 64'(dbl_claim), 64'd0);
        set_src(0, 5'd7, 32'h1);
        bus.src_valid = 4'b0001;
        tick();
        bus.src_valid = '0;
        @(negedge clk);
`ifndef WB_BYPASS_EN
        tick();
        @(negedge clk);
`endif
        check("retire we", 64'(bus.wb_we), 64'd1);
        check("retire busy held", 64'(busy_vec), 64'h80);
        tick();
        @(negedge clk);
        check("retire busy clr", 64'(busy_vec), 64'd0);
        bus.src_valid = 4'b0001;
        tick();
        bus.src_valid = '0;
`ifndef WB_BYPASS_EN
        tick();
`endif
        claim_valid = 1'b1;
        @(negedge clk);
        check("same-edge we", 64'(bus.wb_we), 64'd1);
        tick();
        claim_valid = 1'b0;
        @(negedge clk);
        check("same-edge busy", 64'(busy_vec), 64'h80);
        check("same-edge dbl", 64'(dbl_claim), 64'd0);
        claim_valid = 1'b1;
        tick();
        claim_valid = 1'b0;
        @(negedge clk);
        check("dbl set", 64'(dbl_claim), 64'd1);
        check("dbl busy", 64'(busy_vec), 64'h80);
        tick();
        @(negedge clk);
        check("dbl sticky", 64'(dbl_claim), 64'd1);

        // ---- Test 5: flush ----
        do_reset();
        bus.wb_stall = 1'b1;
        for (int r = 4; r < 8; r++) begin
            claim_valid = 1'b1;
            claim_addr  = AW'(r);
            tick();
        end
        claim_valid = 1'b0;
        for (int i = 0; i < 3; i++) set_src(i, AW'(8 + i), 32'h50 + i);
        bus.src_valid = 4'b0111;
        repeat (3) tick();
        bus.src_valid = '0;
        @(negedge clk);
        check("pre-flush count", 64'(fifo_count), 64'd3);
        check("pre-flush busy", 64'(busy_vec), 64'hF0);
        tick();
        flush         = 1'b1;
        bus.src_valid = 4'b0001;
        claim_valid   = 1'b1;
        claim_addr    = 5'd2;
        @(negedge clk);
        check("flush ready", 64'(bus.src_ready), 64'd0);
        tick();
        flush         = 1'b0;
        bus.src_valid = '0;
        claim_valid   = 1'b0;
        bus.wb_stall  = 1'b0;
        @(negedge clk);
        check("flush count", 64'(fifo_count), 64'd0);
        check("flush busy", 64'(busy_vec), 64'd0);
        check("flush we", 64'(bus.wb_we), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check($sformatf("post-flush[%0d] we", k), 64'(bus.wb_we), 64'd0);
        end

        // ---- Test 6: asynchronous reset mid-drain ----
        do_reset();
        bus.wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) set_src(i, AW'(20 + i), 32'h60 + i);
        bus.src_valid = 4'b0111;
        repeat (3) tick();
        bus.src_valid = '0;
        bus.wb_stall  = 1'b0;
        tick();
        @(negedge clk);
        check("mid-drain we", 64'(bus.wb_we), 64'd1);
        check("mid-drain count", 64'(fifo_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async we", 64'(bus.wb_we), 64'd0);
        check("async addr", 64'(bus.wb_addr), 64'd0);
        check("async data", 64'(bus.wb_data), 64'd0);
        check("async count", 64'(fifo_count), 64'd0);
        check("async busy", 64'(busy_vec), 64'd0);
        check("async ready", 64'(bus.src_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check($sformatf("post-rst[%0d] we", k), 64'(bus.wb_we), 64'd0);
            check($sformatf("post-rst[%0d] count", k), 64'(fifo_count), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
